// File: rtl/layer_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | layer_sequencer_pkg : shared state encoding and default constants  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package layer_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SETTLE = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } seqState_t;

  localparam int c_defaultTimeout = 1024;

endpackage

`default_nettype wire

// File: rtl/seq_watchdog.sv
// +--------------------------------------------------------------------+
// | seq_watchdog : per-layer RUN-cycle watchdog, flags expiry on the    |
// | timeoutCycles-th enabled cycle since the last clear. Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_watchdog
  import layer_sequencer_pkg::*;
#(
  parameter int timeoutCycles = c_defaultTimeout
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int c_cntW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
  localparam logic [c_cntW-1:0] c_lastCount = c_cntW'(timeoutCycles - 1);

  logic [c_cntW-1:0] r_count;

  // Counter parks on the last value so expiry stays asserted until cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_lastCount)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable && (r_count == c_lastCount);

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
// +--------------------------------------------------------------------+
// | layer_sequencer : walks an inference through numLayers chained      |
// | layers. Optional watchdog via macro LAYER_SEQ_TIMEOUT_EN. Rev 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int numLayers     = 3,
  parameter int timeoutCycles = c_defaultTimeout,
  parameter int cycleWidth    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         netInValid,
  output logic                         netInReady,
  output logic [numLayers-1:0]         layerValid,
  input  logic [numLayers-1:0]         layerOutValid,
  output logic [numLayers-1:0]         captureEn,
  output logic                         netOutValid,
  input  logic                         netOutReady,
  output logic [$clog2(numLayers)-1:0] curLayer,
  output logic [cycleWidth-1:0]        cycleCount,
  output logic                         error
);

  localparam int c_idxW = $clog2(numLayers);
  localparam logic [c_idxW-1:0] c_lastLayer = c_idxW'(numLayers - 1);

  seqState_t             r_state;
  seqState_t             w_nextState;
  logic [c_idxW-1:0]     r_curLayer;
  logic [cycleWidth-1:0] r_runCount;
  logic [cycleWidth-1:0] r_cycleCount;
  logic [cycleWidth-1:0] w_runCountInc;
  logic [numLayers-1:0]  w_curOneHot;
  logic                  w_layerDone;
  logic                  w_isLast;
  logic                  w_timeout;

  assign w_curOneHot   = numLayers'(1) << r_curLayer;
  // Only the active layer's completion flag is looked at
  assign w_layerDone   = |(layerOutValid & w_curOneHot);
  assign w_isLast      = (r_curLayer == c_lastLayer);
  assign w_runCountInc = (&r_runCount) ? r_runCount : r_runCount + 1'b1;

`ifdef LAYER_SEQ_TIMEOUT_EN
  logic r_error;

  seq_watchdog #(
    .timeoutCycles(timeoutCycles)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state != RUN),
    .enable (r_state == RUN),
    .expired(w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else if ((r_state == RUN) && (w_nextState == FAULT)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (netInValid) w_nextState = RUN;
      // A completion on the watchdog's last cycle still counts as success
      RUN: begin
        if (w_layerDone) begin
          w_nextState = SETTLE;
        end else if (w_timeout) begin
          w_nextState = FAULT;
        end
      end
      SETTLE:  w_nextState = w_isLast ? DONE : RUN;
      DONE:    if (netOutReady) w_nextState = IDLE;
      FAULT:   w_nextState = FAULT;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    netInReady  = (r_state == IDLE);
    netOutValid = (r_state == DONE);
    layerValid  = '0;
    captureEn   = '0;
    if (r_state == RUN) begin
      layerValid = w_curOneHot;
      if (w_layerDone) begin
        captureEn = w_curOneHot;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_curLayer   <= '0;
      r_runCount   <= '0;
      r_cycleCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (netInValid) begin
            r_curLayer <= '0;
            r_runCount <= '0;
          end
        end
        RUN: begin
          r_runCount <= w_runCountInc;
        end
        // The SETTLE cycle itself is part of the reported latency
        SETTLE: begin
          r_runCount <= w_runCountInc;
          if (w_isLast) begin
            r_cycleCount <= w_runCountInc;
          end else begin
            r_curLayer <= r_curLayer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign curLayer   = r_curLayer;
  assign cycleCount = r_cycleCount;

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_layer_sequencer : directed vector table plus corner sequences   |
// | for layer_sequencer (optionally with LAYER_SEQ_TIMEOUT_EN). Rev 1.0|
// +--------------------------------------------------------------------+
`default_nettype none

module tb_layer_sequencer;

  localparam int c_numLayers = 3;
`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int c_timeout = 24;
`else
  localparam int c_timeout = 8;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   netInValid;
  logic                   netInReady;
  logic [c_numLayers-1:0] layerValid;
  logic [c_numLayers-1:0] layerOutValid;
  logic [c_numLayers-1:0] captureEn;
  logic                   netOutValid;
  logic                   netOutReady;
  logic [1:0]             curLayer;
  logic [15:0]            cycleCount;
  logic                   error;

  layer_sequencer #(
    .numLayers    (c_numLayers),
    .timeoutCycles(c_timeout),
    .cycleWidth   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .netInValid   (netInValid),
    .netInReady   (netInReady),
    .layerValid   (layerValid),
    .layerOutValid(layerOutValid),
    .captureEn    (captureEn),
    .netOutValid  (netOutValid),
    .netOutReady  (netOutReady),
    .curLayer     (curLayer),
    .cycleCount   (cycleCount),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Layer model: raises its done flag on the (lat+1)-th cycle of valid
  int                     layerCnt [c_numLayers];
  int                     layerLat [c_numLayers];
  logic [c_numLayers-1:0] modelOv = '0;
  logic [c_numLayers-1:0] forceOv;
  logic                   modelEn;

  always @(negedge clk) begin
    for (int k = 0; k < c_numLayers; k++) begin
      if (layerValid[k]) layerCnt[k] = layerCnt[k] + 1;
      else               layerCnt[k] = 0;
      modelOv[k] = (layerCnt[k] > layerLat[k]);
    end
  end

  assign layerOutValid = modelEn ? modelOv : forceOv;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [2:0] lv;
    logic [2:0] cap;
    logic [1:0] cur;
    logic       nov;
    logic       nir;
    logic [15:0] cc;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int vi;
    int caps;
    int bad;

    vecs[0]  = '{1,  3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{16, 3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{17, 3'b001, 3'b001, 2'd0, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{18, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{19, 3'b010, 3'b000, 2'd1, 1'b0, 1'b0, 16'd0};
    vecs[5]  = '{35, 3'b010, 3'b010, 2'd1, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{36, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0, 16'd0};
    vecs[7]  = '{37, 3'b100, 3'b000, 2'd2, 1'b0, 1'b0, 16'd0};
    vecs[8]  = '{47, 3'b100, 3'b100, 2'd2, 1'b0, 1'b0, 16'd0};
    vecs[9]  = '{48, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{49, 3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 16'd48};
    vecs[11] = '{52, 3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 16'd48};

    reset       = 1'b0;
    netInValid  = 1'b0;
    netOutReady = 1'b0;
    modelEn     = 1'b1;
    forceOv     = '0;
    layerLat[0] = 16;
    layerLat[1] = 16;
    layerLat[2] = 10;
    for (int k = 0; k < c_numLayers; k++) layerCnt[k] = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_layerValid", layerValid, 3'b000);
    check("rst_captureEn", captureEn, 3'b000);
    check("rst_netOutValid", netOutValid, 1'b0);
    check("rst_curLayer", curLayer, 2'd0);
    check("rst_cycleCount", cycleCount, 16'd0);
    check("rst_error", error, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_netInReady", netInReady, 1'b1);

    // Main three-layer inference: table indexed by cycles after accept
    @(negedge clk);
    netInValid = 1'b1;
    vi   = 0;
    caps = 0;
    for (int cyc = 1; cyc <= 52; cyc++) begin
      @(negedge clk);
      if (cyc == 1) netInValid = 1'b0;
      #1;
      if (captureEn != 3'b000) caps++;
      if (vi < 12 && vecs[vi].cyc == cyc) begin
        check($sformatf("c%0d_layerValid", cyc), layerValid, vecs[vi].lv);
        check($sformatf("c%0d_captureEn", cyc), captureEn, vecs[vi].cap);
        check($sformatf("c%0d_curLayer", cyc), curLayer, vecs[vi].cur);
        check($sformatf("c%0d_netOutValid", cyc), netOutValid, vecs[vi].nov);
        check($sformatf("c%0d_netInReady", cyc), netInReady, vecs[vi].nir);
        check($sformatf("c%0d_cycleCount", cyc), cycleCount, vecs[vi].cc);
        vi++;
      end
    end
    check("capture_pulses", caps, 3);

    // Consumer stalls in DONE while a new request is pending
    netInValid = 1'b1;
    modelEn    = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (netOutValid !== 1'b1 || netInReady !== 1'b0 || layerValid !== 3'b000) bad++;
    end
    check("done_stall", bad, 0);
    netOutReady = 1'b1;
    @(negedge clk);
    #1;
    check("hs_idle_netInReady", netInReady, 1'b1);
    check("hs_idle_netOutValid", netOutValid, 1'b0);
    check("hs_idle_layerValid", layerValid, 3'b000);
    netOutReady = 1'b0;
    @(negedge clk);
    netInValid = 1'b0;
    #1;
    check("reaccept_layerValid", layerValid, 3'b001);
    check("reaccept_curLayer", curLayer, 2'd0);
    check("reaccept_netInReady", netInReady, 1'b0);

    // Completion flag from an inactive layer must be ignored
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      forceOv = 3'b100;
      #1;
      if (captureEn !== 3'b000 || curLayer !== 2'd0 || layerValid !== 3'b001) bad++;
    end
    check("spurious_ignored", bad, 0);
    @(negedge clk);
    forceOv = 3'b001;
    #1;
    check("forced_capture", captureEn, 3'b001);
    @(negedge clk);
    forceOv = 3'b000;
    #1;
    check("forced_settle", layerValid, 3'b000);
    @(negedge clk);
    #1;
    check("forced_layer1_valid", layerValid, 3'b010);
    check("forced_layer1_cur", curLayer, 2'd1);

    // Asynchronous reset in the middle of layer 1
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_layerValid", layerValid, 3'b000);
    check("async_captureEn", captureEn, 3'b000);
    check("async_netOutValid", netOutValid, 1'b0);
    check("async_curLayer", curLayer, 2'd0);
    check("async_cycleCount", cycleCount, 16'd0);
    check("async_error", error, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_netInReady", netInReady, 1'b1);
    netInValid = 1'b1;
    @(negedge clk);
    netInValid = 1'b0;
    #1;
    check("post_rst_layerValid", layerValid, 3'b001);
    check("post_rst_curLayer", curLayer, 2'd0);

    // Layer 0 never responds
`ifdef LAYER_SEQ_TIMEOUT_EN
    bad = 0;
    for (int i = 2; i <= c_timeout; i++) begin
      @(negedge clk);
      #1;
      if (layerValid !== 3'b001 || error !== 1'b0) bad++;
    end
    check("wd_pre_expiry", bad, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      netInValid = 1'b1;
      #1;
      if (layerValid !== 3'b000 || error !== 1'b1 || netInReady !== 1'b0) bad++;
    end
    check("wd_fault_hold", bad, 0);
    netInValid = 1'b0;
    reset = 1'b0;
    #1;
    check("wd_fault_reset_error", error, 1'b0);
    @(negedge clk);
    reset = 1'b1;
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (layerValid !== 3'b001 || error !== 1'b0) bad++;
    end
    check("no_wd_wait", bad, 0);
    check("no_wd_error", error, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
